hc85_seq: RTL and testbench

HC85_SEQ -- requirements
Module: hc85_seq

---
 rtl/hc85_seq_pkg.sv | 11 +
 rtl/hc85.sv | 16 +
 rtl/hc85_seq.sv | 82 ++++++++
 tb/tb_hc85_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hc85_seq_pkg.sv
// hc85_seq_pkg: shared FSM encodings, cascade reset value and NIBBLES bounds for hc85_seq.
package hc85_seq_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam logic [2:0] CASC_RST = 3'b010;
    localparam int NIBBLES_MIN = 1;
    localparam int NIBBLES_MAX = 8;
endpackage

// File: rtl/hc85.sv
// hc85: 4-bit magnitude comparator with {lt,eq,gt} cascade inputs, 74HC85 style.
module hc85 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       lt_in,
    input  logic       eq_in,
    input  logic       gt_in,
    output logic       lt,
    output logic       eq,
    output logic       gt
);
    // Equal nibbles defer to the cascade; eq_in dominates as on the real part.
    assign eq = (a == b) & eq_in;
    assign gt = (a > b) | ((a == b) & ~eq_in & gt_in);
    assign lt = (a < b) | ((a == b) & ~eq_in & lt_in);
endmodule

// File: rtl/hc85_seq.sv
// hc85_seq: serial multi-nibble unsigned magnitude compare using one hc85, LSB nibble first.
module hc85_seq
    import hc85_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a_in,
    input  logic [4*NIBBLES-1:0] b_in,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 oa_lt_b,
    output logic                 oa_eq_b,
    output logic                 oa_gt_b
);
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    if (NIBBLES < NIBBLES_MIN || NIBBLES > NIBBLES_MAX) begin : g_bad_nibbles
        $error("hc85_seq: NIBBLES out of range");
    end

    state_t               state, state_d;
    logic [IW-1:0]        idx;
    logic [4*NIBBLES-1:0] a_r, b_r, a_sh, b_sh;
    logic [2:0]           casc, res;
    logic                 lt, eq, gt, last;

    assign a_sh = a_r >> {idx, 2'b00};
    assign b_sh = b_r >> {idx, 2'b00};
    assign last = idx == LAST;

    hc85 u_hc85 (
        .a     (a_sh[3:0]),
        .b     (b_sh[3:0]),
        .lt_in (casc[2]),
        .eq_in (casc[1]),
        .gt_in (casc[0]),
        .lt    (lt),
        .eq    (eq),
        .gt    (gt)
    );

    always_comb begin
        state_d = IDLE;
        state_d = (state == IDLE) ? (start ? RUN : IDLE) :
                  (state == RUN)  ? (abort ? IDLE : (last ? DONE : RUN)) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            casc  <= CASC_RST;
            res   <= CASC_RST;
        end else begin
            state <= state_d;
            if (state == IDLE && start) begin
                a_r  <= a_in;
                b_r  <= b_in;
                idx  <= '0;
                casc <= CASC_RST;
            end else if (state == RUN) begin
                // idx parks at 0 on exit so it never wraps past LAST.
                idx <= (abort || last) ? '0 : idx + 1'b1;
                if (!abort) casc <= {lt, eq, gt};
                if (!abort && last) res <= {lt, eq, gt};
            end
        end
    end

    assign busy    = state == RUN;
    assign done    = state == DONE;
    assign oa_lt_b = res[2];
    assign oa_eq_b = res[1];
    assign oa_gt_b = res[0];
endmodule

// File: tb/tb_hc85_seq.sv
// tb_hc85_seq: directed self-checking bench for hc85_seq with NIBBLES=4.
module tb_hc85_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic        busy, done, oa_lt_b, oa_eq_b, oa_gt_b;
    int          n_cmp = 0;
    int          n_bad = 0;

    hc85_seq #(.NIBBLES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .abort   (abort),
        .busy    (busy),
        .done    (done),
        .oa_lt_b (oa_lt_b),
        .oa_eq_b (oa_eq_b),
        .oa_gt_b (oa_gt_b)
    );

    always #10 clk = ~clk;

    // Inputs are inverted right after capture so a missing capture shows up.
    task automatic do_start(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = ~a;
        b_in  = ~b;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 20);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_busy_done: got %b expected 00", {busy, done});
        end
        n_cmp++;
        if ({oa_lt_b, oa_eq_b, oa_gt_b} !== 3'b010) begin
            n_bad++;
            $display("FAIL reset_result: got %b expected 010", {oa_lt_b, oa_eq_b, oa_gt_b});
        end
    endtask

    task automatic test_equal;
        int cyc;
        do_start(16'hA5A5, 16'hA5A5);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL equal_busy: got %b expected 1", busy);
        end
        wait_done(cyc);
        n_cmp++;
        if (cyc !== 5) begin
            n_bad++;
            $display("FAIL equal_latency: got %0d expected 5", cyc);
        end
        n_cmp++;
        if ({oa_lt_b, oa_eq_b, oa_gt_b} !== 3'b010) begin
            n_bad++;
            $display("FAIL equal_result: got %b expected 010", {oa_lt_b, oa_eq_b, oa_gt_b});
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, done, oa_lt_b, oa_eq_b, oa_gt_b} !== 5'b00010) begin
            n_bad++;
            $display("FAIL equal_pulse_hold: got %b expected 00010", {busy, done, oa_lt_b, oa_eq_b, oa_gt_b});
        end
    endtask

    task automatic test_msb;
        int cyc;
        do_start(16'h1000, 16'h0FFF);
        wait_done(cyc);
        n_cmp++;
        if (cyc !== 5 || {oa_lt_b, oa_eq_b, oa_gt_b} !== 3'b001) begin
            n_bad++;
            $display("FAIL msb_gt: got cyc=%0d res=%b expected cyc=5 res=001", cyc, {oa_lt_b, oa_eq_b, oa_gt_b});
        end
        do_start(16'h0FFF, 16'h1000);
        wait_done(cyc);
        n_cmp++;
        if (cyc !== 5 || {oa_lt_b, oa_eq_b, oa_gt_b} !== 3'b100) begin
            n_bad++;
            $display("FAIL msb_lt: got cyc=%0d res=%b expected cyc=5 res=100", cyc, {oa_lt_b, oa_eq_b, oa_gt_b});
        end
    endtask

    task automatic test_low_nibble;
        int cyc;
        do_start(16'h0003, 16'h0004);
        wait_done(cyc);
        n_cmp++;
        if ({done, oa_lt_b, oa_eq_b, oa_gt_b} !== 4'b1100) begin
            n_bad++;
            $display("FAIL low_nibble_lt: got %b expected 1100", {done, oa_lt_b, oa_eq_b, oa_gt_b});
        end
        do_start(16'h8001, 16'h8000);
        wait_done(cyc);
        n_cmp++;
        if ({done, oa_lt_b, oa_eq_b, oa_gt_b} !== 4'b1001) begin
            n_bad++;
            $display("FAIL low_nibble_gt: got %b expected 1001", {done, oa_lt_b, oa_eq_b, oa_gt_b});
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        int pulses;
        do_start(16'h0003, 16'h0004);
        @(negedge clk);
        start = 1'b1;
        a_in  = 16'hFFFF;
        b_in  = 16'h0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc);
        n_cmp++;
        if (cyc !== 4 || {oa_lt_b, oa_eq_b, oa_gt_b} !== 3'b100) begin
            n_bad++;
            $display("FAIL b2b_first: got cyc=%0d res=%b expected cyc=4 res=100", cyc, {oa_lt_b, oa_eq_b, oa_gt_b});
        end
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) pulses++;
        end
        n_cmp++;
        if (pulses !== 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_no_queue: got pulses=%0d busy=%b expected 0 0", pulses, busy);
        end
    endtask

    task automatic test_abort;
        int cyc;
        int pulses;
        do_start(16'h1234, 16'h1234);
        wait_done(cyc);
        do_start(16'hFFFF, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        n_cmp++;
        if ({busy, done, oa_lt_b, oa_eq_b, oa_gt_b} !== 5'b00010) begin
            n_bad++;
            $display("FAIL abort_idle: got %b expected 00010", {busy, done, oa_lt_b, oa_eq_b, oa_gt_b});
        end
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) pulses++;
        end
        n_cmp++;
        if (pulses !== 0 || {oa_lt_b, oa_eq_b, oa_gt_b} !== 3'b010) begin
            n_bad++;
            $display("FAIL abort_no_done: got pulses=%0d res=%b expected 0 010", pulses, {oa_lt_b, oa_eq_b, oa_gt_b});
        end
        @(negedge clk);
        abort = 1'b1;
        do_start(16'h0000, 16'h0001);
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL start_beats_abort: got busy=%b expected 1", busy);
        end
        wait_done(cyc);
        n_cmp++;
        if (cyc !== 5 || {oa_lt_b, oa_eq_b, oa_gt_b} !== 3'b100) begin
            n_bad++;
            $display("FAIL start_beats_abort_res: got cyc=%0d res=%b expected cyc=5 res=100", cyc, {oa_lt_b, oa_eq_b, oa_gt_b});
        end
    endtask

    task automatic test_reset_mid_run;
        int cyc;
        do_start(16'h1000, 16'h0FFF);
        wait_done(cyc);
        do_start(16'h0000, 16'hFFFF);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        n_cmp++;
        if ({busy, done, oa_lt_b, oa_eq_b, oa_gt_b} !== 5'b00010) begin
            n_bad++;
            $display("FAIL reset_mid_run: got %b expected 00010", {busy, done, oa_lt_b, oa_eq_b, oa_gt_b});
        end
        do_start(16'h0001, 16'h0000);
        wait_done(cyc);
        n_cmp++;
        if (cyc !== 5 || {oa_lt_b, oa_eq_b, oa_gt_b} !== 3'b001) begin
            n_bad++;
            $display("FAIL reset_then_fresh: got cyc=%0d res=%b expected cyc=5 res=001", cyc, {oa_lt_b, oa_eq_b, oa_gt_b});
        end
    endtask

    initial begin
        test_reset;
        test_equal;
        test_msb;
        test_low_nibble;
        test_back_to_back;
        test_abort;
        test_reset_mid_run;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
